// File: rtl/can_busoff_pkg.sv
// Shared types and constants for the CAN bus-off recovery sequencer.
package can_busoff_pkg;

  localparam int RUN_LEN_DEF = 11;
  localparam int OCC_MAX_DEF = 128;

  localparam logic [2:0] ST_ENC_IDLE  = 3'b000;
  localparam logic [2:0] ST_ENC_ARMED = 3'b001;
  localparam logic [2:0] ST_ENC_RUN   = 3'b010;
  localparam logic [2:0] ST_ENC_DONE  = 3'b011;
  localparam logic [2:0] ST_ENC_HOLD  = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE  = ST_ENC_IDLE,
    ST_ARMED = ST_ENC_ARMED,
    ST_RUN   = ST_ENC_RUN,
    ST_DONE  = ST_ENC_DONE,
    ST_HOLD  = ST_ENC_HOLD
  } busoff_state_t;

endpackage

// File: rtl/busoff_run_det.sv
// Counts consecutive recessive samples; run_done is a combinational pulse on the
// strobe that completes a run of RUN_LEN recessive bits.
module busoff_run_det #(
  parameter int RUN_LEN = 11
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic smpl_en,
  input  logic rx_bit,
  output logic run_done
);

  localparam int CW = $clog2(RUN_LEN);

  logic [CW-1:0] run_cnt;
  logic          last_bit;

  assign last_bit = (run_cnt == CW'(RUN_LEN - 1));
  assign run_done = !clear && smpl_en && rx_bit && last_bit;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      run_cnt <= '0;
    end else if (clear) begin
      run_cnt <= '0;
    end else if (smpl_en) begin
      if (!rx_bit || last_bit) run_cnt <= '0;
      else                     run_cnt <= run_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/busoff_recovery_ctrl.sv
// Bus-off recovery sequencer: counts OCC_MAX runs of RUN_LEN recessive bits while
// bus-off, then pulses recov_done once and holds until busoff drops.
module busoff_recovery_ctrl
  import can_busoff_pkg::*;
#(
  parameter int RUN_LEN = RUN_LEN_DEF,
  parameter int OCC_MAX = OCC_MAX_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       busoff,
  input  logic       auto_restart,
  input  logic       restart_req,
  input  logic       smpl_en,
  input  logic       rx_bit,
  output logic       elevrecb,
  output logic [7:0] occ_cnt,
  output logic       recov_done,
  output logic       recov_active,
  output logic [2:0] state_o
);

  busoff_state_t state_q, state_d;
  logic [7:0]    occ_q, occ_d;
  logic          run_clear;
  logic          run_done;

  // Counting only happens in RUN with busoff still asserted; an abort wins over a strobe.
  assign run_clear = (state_q != ST_RUN) || !busoff;

  busoff_run_det #(.RUN_LEN(RUN_LEN)) u_run_det (
    .clock    (clock),
    .reset    (reset),
    .clear    (run_clear),
    .smpl_en  (smpl_en),
    .rx_bit   (rx_bit),
    .run_done (run_done)
  );

  always_comb begin
    state_d = state_q;
    occ_d   = occ_q;
    unique case (state_q)
      ST_IDLE:  if (busoff) state_d = auto_restart ? ST_RUN : ST_ARMED;
      ST_ARMED: begin
        if (!busoff)          state_d = ST_IDLE;
        else if (restart_req) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!busoff) state_d = ST_IDLE;
        else if (run_done && occ_q == 8'(OCC_MAX - 1)) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_HOLD;
      ST_HOLD:  if (!busoff) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (state_d == ST_IDLE)                      occ_d = '0;
    else if (run_done && occ_q < 8'(OCC_MAX))    occ_d = occ_q + 8'd1;
  end

  // elevrecb and recov_done are single-cycle pulses with no back-pressure; the fault
  // FSM must sample them on the cycle they are high.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      occ_q        <= '0;
      elevrecb     <= 1'b0;
      recov_done   <= 1'b0;
      recov_active <= 1'b0;
    end else begin
      state_q      <= state_d;
      occ_q        <= occ_d;
      elevrecb     <= run_done;
      recov_done   <= (state_q == ST_DONE);
      recov_active <= (state_d == ST_RUN);
    end
  end

  assign occ_cnt = occ_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_busoff_recovery_ctrl.sv
// Directed bench for busoff_recovery_ctrl with a pulse scoreboard fed by the stimulus.
module tb_busoff_recovery_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       busoff = 1'b0;
  logic       auto_restart = 1'b0;
  logic       restart_req = 1'b0;
  logic       smpl_en = 1'b0;
  logic       rx_bit = 1'b0;
  logic       elevrecb;
  logic [7:0] occ_cnt;
  logic       recov_done;
  logic       recov_active;
  logic [2:0] state_o;

  int n_checks = 0;
  int n_pass   = 0;
  int n_elev   = 0;
  int n_done   = 0;

  // Expected pulse entries: {elevrecb, recov_done, occ_cnt}
  logic [9:0] exp_q[$];

  busoff_recovery_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .busoff       (busoff),
    .auto_restart (auto_restart),
    .restart_req  (restart_req),
    .smpl_en      (smpl_en),
    .rx_bit       (rx_bit),
    .elevrecb     (elevrecb),
    .occ_cnt      (occ_cnt),
    .recov_done   (recov_done),
    .recov_active (recov_active),
    .state_o      (state_o)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic strobe(input logic b);
    smpl_en = 1'b1;
    rx_bit  = b;
    tick();
    smpl_en = 1'b0;
    rx_bit  = 1'b0;
    tick();
  endtask

  // n recessive strobes; a run completes on every 11th, taking occ_cnt to start_occ + i/11
  task automatic run_ones(input int n, input int start_occ);
    for (int i = 1; i <= n; i++) begin
      if (i % 11 == 0) exp_q.push_back({2'b10, 8'(start_occ + i / 11)});
      strobe(1'b1);
    end
  endtask

  task automatic check_state(input string name, input logic [2:0] st, input logic [7:0] occ);
    check({name, "_state"}, 32'(state_o), 32'(st));
    check({name, "_occ"}, 32'(occ_cnt), 32'(occ));
  endtask

  // Monitor: every output pulse must match the next scoreboard entry
  always @(negedge clock) begin
    logic [9:0] act;
    logic [9:0] e;
    if (!reset && (elevrecb || recov_done)) begin
      act = {elevrecb, recov_done, occ_cnt};
      if (elevrecb)   n_elev++;
      if (recov_done) n_done++;
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 32'(act), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("pulse", 32'(act), 32'(e));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int elev_base;

    #12;
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_occ", 32'(occ_cnt), 32'd0);
    check("rst_elevrecb", 32'(elevrecb), 32'd0);
    check("rst_recov_done", 32'(recov_done), 32'd0);
    check("rst_recov_active", 32'(recov_active), 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    tick();

    // Auto recovery: 1408 recessive strobes -> 128 runs -> recov_done
    auto_restart = 1'b1;
    busoff = 1'b1;
    tick();
    check_state("auto_entry", 3'b010, 8'd0);
    check("auto_active", 32'(recov_active), 32'd1);
    run_ones(1408, 0);
    exp_q.push_back({2'b01, 8'd128});
    check("auto_recov_done", 32'(recov_done), 32'd1);
    check_state("auto_hold", 3'b100, 8'd128);
    check("auto_inactive", 32'(recov_active), 32'd0);
    for (int k = 0; k < 3; k++) begin
      strobe(1'b1);
      check_state("hold_guard", 3'b100, 8'd128);
    end
    check("auto_elev_count", 32'(n_elev), 32'd128);
    check("auto_done_count", 32'(n_done), 32'd1);
    busoff = 1'b0;
    tick();
    check_state("auto_exit", 3'b000, 8'd0);
    tick();

    // Broken run; busoff rises with a strobe that must not be counted
    elev_base = n_elev;
    busoff = 1'b1;
    smpl_en = 1'b1;
    rx_bit = 1'b1;
    tick();
    smpl_en = 1'b0;
    tick();
    check_state("broken_entry", 3'b010, 8'd0);
    run_ones(10, 0);
    strobe(1'b0);
    run_ones(11, 0);
    check_state("broken_one", 3'b010, 8'd1);
    run_ones(10, 1);
    strobe(1'b0);
    check("occ_kept_after_dominant", 32'(occ_cnt), 32'd1);
    check("broken_elev_count", 32'(n_elev - elev_base), 32'd1);

    // Abort with occ_cnt=57 on a completing strobe
    run_ones(616, 1);
    check("abort_pre_occ", 32'(occ_cnt), 32'd57);
    run_ones(10, 57);
    busoff = 1'b0;
    smpl_en = 1'b1;
    rx_bit = 1'b1;
    tick();
    smpl_en = 1'b0;
    check_state("abort", 3'b000, 8'd0);
    check("abort_elevrecb", 32'(elevrecb), 32'd0);
    tick();

    // Manual mode
    auto_restart = 1'b0;
    busoff = 1'b1;
    tick();
    check_state("armed_entry", 3'b001, 8'd0);
    for (int k = 0; k < 30; k++) strobe(1'b1);
    check_state("armed_wait", 3'b001, 8'd0);
    check("armed_inactive", 32'(recov_active), 32'd0);
    restart_req = 1'b1;
    smpl_en = 1'b1;
    rx_bit = 1'b1;
    tick();
    restart_req = 1'b0;
    smpl_en = 1'b0;
    check_state("restart", 3'b010, 8'd0);
    tick();
    for (int k = 0; k < 10; k++) strobe(1'b1);
    check("restart_strobe_not_counted", 32'(occ_cnt), 32'd0);
    exp_q.push_back({2'b10, 8'd1});
    strobe(1'b1);
    check("manual_first_run", 32'(occ_cnt), 32'd1);

    // Async reset mid-run with occ_cnt=100
    run_ones(1089, 1);
    check("reset_pre_occ", 32'(occ_cnt), 32'd100);
    for (int k = 0; k < 5; k++) strobe(1'b1);
    #2 reset = 1'b1;
    #1;
    check("async_state", 32'(state_o), 32'd0);
    check("async_occ", 32'(occ_cnt), 32'd0);
    check("async_elevrecb", 32'(elevrecb), 32'd0);
    check("async_recov_done", 32'(recov_done), 32'd0);
    check("async_recov_active", 32'(recov_active), 32'd0);
    busoff = 1'b0;
    @(posedge clock);
    #1 reset = 1'b0;
    tick();
    check_state("post_reset", 3'b000, 8'd0);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/busoff_recovery_ctrl.md
# busoff_recovery_ctrl

Sequencer for CAN bus-off recovery. While the fault confinement FSM reports bus-off, this block watches the sampled bus level and detects runs of eleven consecutive recessive bits. It counts 128 such runs and then issues a single recovery pulse that tells the fault FSM to clear TEC/REC and return to error-active. It sits between the MAC bit-sampling stage and the fault FSM, and its per-run pulse is compatible with the existing eleven-received-bits counter interface.

## Interface
Parameters:
- RUN_LEN, 11: consecutive recessive samples that form one occurrence.
- OCC_MAX, 128: occurrences required before recovery.

Ports:
- clock, input, 1: system clock, all logic on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- busoff, input, 1: fault FSM is in the bus-off state (level).
- auto_restart, input, 1: 1 starts recovery on bus-off entry; 0 waits for restart_req.
- restart_req, input, 1: single-cycle host request to begin recovery.
- smpl_en, input, 1: single-cycle strobe at each bit sample point.
- rx_bit, input, 1: sampled bus level, 1 is recessive. Valid only when smpl_en=1.
- elevrecb, output, 1: single-cycle pulse for each completed run of RUN_LEN recessive bits.
- occ_cnt, output, 8: occurrences counted so far. Saturates at OCC_MAX.
- recov_done, output, 1: single-cycle pulse to the fault FSM to clear the error counters.
- recov_active, output, 1: high in RUN.
- state_o, output, 3: current FSM state encoding.

## Operation
- States and encodings: IDLE=000, ARMED=001, RUN=010, DONE=011, HOLD=100.
- IDLE:
  - busoff=1 and auto_restart=1 → RUN.
  - busoff=1 and auto_restart=0 → ARMED.
  - run_cnt and occ_cnt are held at 0.
  - restart_req is ignored.
- ARMED:
  - restart_req=1 → RUN.
  - busoff=0 → IDLE. This has priority over restart_req.
- RUN, on each smpl_en:
  - rx_bit=1: run_cnt increments. When run_cnt reaches RUN_LEN-1 before the increment, the run completes:
    - run_cnt goes to 0, occ_cnt increments, and elevrecb pulses.
    - If occ_cnt was OCC_MAX-1 before this completion, the next state is DONE.
  - rx_bit=0: run_cnt goes to 0. occ_cnt is kept, because only the current run is broken.
  - Outside smpl_en strobes, rx_bit is ignored.
- RUN, busoff=0 (abort): → IDLE, counters cleared, no elevrecb or recov_done. This has priority over a simultaneous smpl_en.
- DONE: recov_done=1 for exactly this one cycle, then → HOLD.
- HOLD: wait for busoff=0, then → IDLE. This prevents the fault FSM's exit latency from re-triggering recovery.
- Counter widths:
  - run_cnt is $clog2(RUN_LEN) bits and never exceeds RUN_LEN-1.
  - occ_cnt is 8 bits and never exceeds OCC_MAX.
- Reset mid-operation clears state to IDLE and all counters to 0, with no output pulse.

## Timing
- Reset values: elevrecb=0, occ_cnt=0, recov_done=0, recov_active=0, state_o=000.
- All outputs are registered.
- elevrecb and the occ_cnt update appear 1 cycle after the smpl_en that completes a run.
- recov_done is asserted in the cycle after the final elevrecb.
- The first run completes RUN_LEN strobes after RUN entry.
- From RUN entry to recov_done takes at least RUN_LEN×OCC_MAX strobes (1408 with defaults), plus 2 cycles.
- restart_req and smpl_en in the same cycle in ARMED: the state moves to RUN and that sample is not counted.
- busoff rising in IDLE: RUN or ARMED is reached 1 cycle later. A strobe in that same cycle is not counted.
- smpl_en strobes are assumed at least 2 cycles apart. Back-to-back strobes are still handled correctly, one sample per cycle.

## Structure
- Shared package can_busoff_pkg holds:
  - the state enum busoff_state_t;
  - the RUN_LEN_DEF=11 and OCC_MAX_DEF=128 constants;
  - the state_o encodings.
- One sub-module, busoff_run_det, holds the run_cnt counter and generates the completion pulse. Its inputs are clear, smpl_en and rx_bit; its output is run_done. The top level holds the FSM and occ_cnt.

## Test plan
- Auto recovery: set auto_restart=1, raise busoff, then drive 1408 recessive strobes.
  - Required: 128 elevrecb pulses and occ_cnt=128.
  - Required: recov_done pulses once, the state reaches HOLD, and it returns to IDLE after busoff drops.
- Broken run: drive 10 recessive strobes, 1 dominant, then 11 recessive.
  - Required: exactly 1 elevrecb, occ_cnt=1, and the count is not reset by the dominant bit.
- Manual mode: set auto_restart=0, raise busoff, and drive 30 recessive strobes.
  - Required: state ARMED and occ_cnt=0.
  - Then pulse restart_req together with a strobe. Required: RUN is entered and that strobe is not counted.
- Abort: drop busoff in RUN with occ_cnt=57, in the same cycle as a completing strobe.
  - Required: IDLE next cycle, occ_cnt=0, and no elevrecb.
- Async reset: assert reset mid-run with occ_cnt=100.
  - Required: all outputs go to 0 immediately, before the next clock edge.
- Re-trigger guard: keep busoff=1 for 5 cycles after recov_done.
  - Required: state stays in HOLD and there is no second recov_done.
